cntr_bank: RTL and testbench

CNTR_BANK -- requirements
Module: cntr_bank

---
 rtl/cntr_bank.sv | 111 +++++++++++
 tb/tb_cntr_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cntr_bank.sv
// cntr_bank: bank of prescaled up/down counters with optional
// cascade (carry ripple), saturation, per-channel load and clear.
module cntr_bank #(
    parameter int NCH = 5,
    parameter int W   = 2,
    parameter int PW  = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NCH-1:0]   en_i,
    input  logic [NCH-1:0]   dir_i,
    input  logic             sat_i,
    input  logic             chain_i,
    input  logic             clr_i,
    input  logic [NCH-1:0]   load_i,
    input  logic [NCH*W-1:0] load_val_i,
    input  logic [PW-1:0]    prescale_i,
    output logic [NCH*W-1:0] cnt_o,
    output logic [NCH-1:0]   wrap_o,
    output logic             tick_o
);

    localparam logic [W-1:0]  MAXV  = {W{1'b1}};
    localparam logic [W-1:0]  ONE   = W'(1);
    localparam logic [PW-1:0] PONE  = PW'(1);

    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic             tick;
    logic [NCH*W-1:0] cnt_q;
    logic [NCH*W-1:0] cnt_d;
    logic [NCH-1:0]   step;
    logic [NCH-1:0]   evt;

    // Prescaler: tick when pre reaches the period, clear wins.
    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q;
        if (clr_i) begin
            pre_d = '0;
        end else if (pre_q >= prescale_i) begin
            tick  = 1'b1;
            pre_d = '0;
        end else begin
            pre_d = pre_q + PONE;
        end
    end

    // Step/wrap ripple across channels, plus next counter values.
    always_comb begin
        logic           carry;
        logic           s;
        logic           e;
        logic           at_end;
        logic [W-1:0]   cur;
        logic [W-1:0]   nxt;
        step  = '0;
        evt   = '0;
        cnt_d = cnt_q;
        carry = 1'b0;
        s     = 1'b0;
        e     = 1'b0;
        at_end = 1'b0;
        cur   = '0;
        nxt   = '0;
        for (int k = 0; k < NCH; k++) begin
            cur = cnt_q[k*W +: W];
            if (k == 0 || !chain_i)
                s = tick & en_i[k];
            else
                s = en_i[k] & carry;
            at_end = dir_i[k] ? (cur == MAXV) : (cur == '0);
            e = s & ~sat_i & at_end & ~load_i[k] & ~clr_i;
            step[k] = s;
            evt[k]  = e;
            carry   = e;
            nxt = cur;
            if (clr_i) begin
                nxt = '0;
            end else if (load_i[k]) begin
                nxt = load_val_i[k*W +: W];
            end else if (s) begin
                if (sat_i && at_end)
                    nxt = cur;
                else if (dir_i[k])
                    nxt = cur + ONE;
                else
                    nxt = cur - ONE;
            end
            cnt_d[k*W +: W] = nxt;
        end
    end

    // State and registered outputs; reset discards everything.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            wrap_o <= '0;
            tick_o <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            wrap_o <= evt;
            tick_o <= tick;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_cntr_bank.sv
// tb_cntr_bank: directed vectors for cntr_bank (NCH=5, W=2, PW=8)
// with hand-computed expectations.
module tb_cntr_bank;

    logic       clk;
    logic       rst_n;
    logic [4:0] en;
    logic [4:0] dir;
    logic       sat;
    logic       chain;
    logic       clr;
    logic [4:0] load;
    logic [9:0] load_val;
    logic [7:0] prescale;
    logic [9:0] cnt;
    logic [4:0] wrap;
    logic       tick;

    int n_vec;
    int n_err;

    cntr_bank #(.NCH(5), .W(2), .PW(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .en_i       (en),
        .dir_i      (dir),
        .sat_i      (sat),
        .chain_i    (chain),
        .clr_i      (clr),
        .load_i     (load),
        .load_val_i (load_val),
        .prescale_i (prescale),
        .cnt_o      (cnt),
        .wrap_o     (wrap),
        .tick_o     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en = '0; dir = '0; sat = 1'b0; chain = 1'b0;
        clr = 1'b0; load = '0; load_val = '0; prescale = '0;
        #2;
        check("rst_cnt", {22'd0, cnt}, 32'h0);
        check("rst_wrap", {27'd0, wrap}, 32'h0);
        check("rst_tick", {31'd0, tick}, 32'h0);

        // free run, all up, no prescale
        en = 5'h1F; dir = 5'h1F;
        #1 rst_n = 1'b1;
        cyc();
        check("free1", {22'd0, cnt}, 32'h155);
        check("free1_tick", {31'd0, tick}, 32'h1);
        cyc();
        check("free2", {22'd0, cnt}, 32'h2AA);
        cyc();
        check("free3", {22'd0, cnt}, 32'h3FF);
        check("free3_wrap", {27'd0, wrap}, 32'h0);
        cyc();
        check("free4", {22'd0, cnt}, 32'h000);
        check("free4_wrap", {27'd0, wrap}, 32'h1F);
        cyc();
        check("free5", {22'd0, cnt}, 32'h155);
        check("free5_wrap", {27'd0, wrap}, 32'h0);

        // prescaler period 4 on ch0
        clr = 1'b1;
        cyc();
        check("clr_cnt", {22'd0, cnt}, 32'h0);
        check("clr_tick", {31'd0, tick}, 32'h0);
        clr = 1'b0; prescale = 8'd3; en = 5'h01;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            check("pre_cnt", {22'd0, cnt}, 32'(i / 4));
            check("pre_tick", {31'd0, tick}, 32'((i % 4) == 0));
        end

        // cascade
        clr = 1'b1; chain = 1'b1; prescale = 8'd0; en = 5'h1F;
        cyc();
        clr = 1'b0;
        for (int n = 1; n <= 1024; n++) begin
            cyc();
            if (n == 4) begin
                check("cas4", {22'd0, cnt}, 32'h004);
                check("cas4_wrap", {27'd0, wrap}, 32'h01);
            end
            if (n == 16) begin
                check("cas16", {22'd0, cnt}, 32'h010);
                check("cas16_wrap", {27'd0, wrap}, 32'h03);
            end
            if (n == 1023) begin
                check("cas1023", {22'd0, cnt}, 32'h3FF);
                check("cas1023_wrap", {27'd0, wrap}, 32'h0);
            end
            if (n == 1024) begin
                check("cas1024", {22'd0, cnt}, 32'h000);
                check("cas1024_wrap", {27'd0, wrap}, 32'h1F);
            end
        end

        // saturate down then up on ch0
        chain = 1'b0; sat = 1'b1; dir = 5'h00; en = 5'h01;
        load = 5'h01; load_val = 10'h002;
        cyc();
        check("sat_load", {22'd0, cnt}, 32'h002);
        load = 5'h00;
        cyc();
        check("satd1", {22'd0, cnt}, 32'h001);
        cyc();
        check("satd0", {22'd0, cnt}, 32'h000);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("satd_hold", {22'd0, cnt}, 32'h000);
            check("satd_wrap", {27'd0, wrap}, 32'h0);
        end
        load = 5'h01; load_val = 10'h002; dir = 5'h1F;
        cyc();
        load = 5'h00;
        cyc();
        check("satu3", {22'd0, cnt}, 32'h003);
        cyc();
        check("satu_hold", {22'd0, cnt}, 32'h003);
        check("satu_wrap", {27'd0, wrap}, 32'h0);

        // priority: clear over load over step
        sat = 1'b0; en = 5'h1F; dir = 5'h1F;
        load = 5'h1F; load_val = 10'h3FF;
        cyc();
        check("pri_load", {22'd0, cnt}, 32'h3FF);
        check("pri_load_wrap", {27'd0, wrap}, 32'h0);
        clr = 1'b1;
        cyc();
        check("pri_clr", {22'd0, cnt}, 32'h000);
        check("pri_clr_tick", {31'd0, tick}, 32'h0);
        clr = 1'b0;
        cyc();
        check("pri_reload", {22'd0, cnt}, 32'h3FF);
        load = 5'h01; load_val = 10'h001; en = 5'h01;
        cyc();
        check("pri_ld_step", {22'd0, cnt}, 32'h3FD);
        check("pri_ld_wrap", {27'd0, wrap}, 32'h0);

        // async reset mid-count
        load = 5'h00; en = 5'h1F;
        cyc();
        check("pre_rst", {22'd0, cnt}, 32'h002);
        check("pre_rst_wrap", {27'd0, wrap}, 32'h1E);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", {22'd0, cnt}, 32'h0);
        check("arst_wrap", {27'd0, wrap}, 32'h0);
        check("arst_tick", {31'd0, tick}, 32'h0);
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        check("restart", {22'd0, cnt}, 32'h155);
        check("restart_wrap", {27'd0, wrap}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
